mux_scan_sequencer: RTL
=======================

Name: mux_scan_sequencer

Overview:
- Drives the 2-bit select of the 4:1 multiplexer stage and captures its 1-bit output Y.
- Steps the select through channels 0..3, dwelling DWELL cycles on each. Samples Y on the last dwell cycle.
- Assembles the four samples into a 4-bit frame and offers it downstream with a valid/ready handshake.
- Sits around the mux: upstream of the mux select, downstream of the mux output.

Parameters:
- DWELL, 4, cycles spent on each channel before sampling; legal range 1..255.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle request to begin a scan; honoured only in IDLE.
- continuous  in  1  when 1, a new scan starts automatically after each frame is accepted.
- sel  out  2  select to the mux S input.
- y  in  1  mux output Y.
- frame  out  4  captured frame; bit k = y sampled while sel == k.
- frame_valid  out  1  frame is available.
- frame_ready  in  1  consumer accepts the frame.
- busy  out  1  high in SCAN and OUT.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-scan or mid-handshake): state=IDLE, sel=0, frame=0, frame_valid=0, busy=0, dwell count=0. All partial samples are discarded.
- States: IDLE, SCAN, OUT.
- IDLE:
  - sel=0, busy=0.
  - start=1 at an edge -> SCAN with sel=0, count=0.
- SCAN:
  - count increments each edge.
  - At the edge where count==DWELL-1, y is written into frame shadow bit[sel] and count resets to 0.
    - If sel<3: sel increments.
    - If sel==3: the shadow is copied to frame and the state moves to OUT.
  - Latency: frame_valid rises exactly 4*DWELL edges after the edge that sampled start.
  - start is ignored.
- OUT:
  - frame_valid=1. frame is stable until accepted. sel holds at 3.
  - frame_ready=1 at an edge means the frame is accepted; frame_valid drops after that edge.
    - If continuous=1: -> SCAN with sel=0, count=0.
    - Otherwise: -> IDLE with sel=0.
  - frame_ready=0: hold indefinitely, with no sampling and no loss.
- frame_ready outside OUT is ignored.
- continuous is sampled only at the accepting edge.
- frame retains its last value in IDLE and SCAN. It updates only on the SCAN->OUT transition.
- DWELL=1: one cycle per channel, so y is sampled in the same cycle sel is presented. The mux path must be combinational.
- Simultaneous start and rst: rst wins.

Optional Feature:
- Macro SCAN_PARITY_EN.
- Defined: adds output frame_parity (1 bit). It equals the XOR of the 4 frame bits, is registered together with frame, is valid whenever frame_valid=1, and resets to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SCAN, OUT}
  - NUM_CH=4
  - SEL_W=2
  - FRAME_W=NUM_CH
- Sub-module dwell_counter:
  - 8-bit counter with clear and enable inputs.
  - Asserts terminal output when count==DWELL-1.
  - Same clk/rst.

Test Plan:
- Mux inputs I=4'b0110, DWELL=4, start pulse -> sel sequence 0,1,2,3, each held 4 cycles. frame_valid rises 16 edges after start; frame=4'b0110; busy=1 throughout.
- Hold frame_ready=0 for 10 cycles in OUT -> frame_valid stays 1, frame stays 4'b0110, sel stays 3. Then ready=1 for one cycle -> IDLE, sel=0, busy=0.
- continuous=1; change I to 4'b1001 after the first frame -> second frame=4'b1001 with no start pulse, first sel=0 on the edge after acceptance.
- Assert rst 6 cycles into a scan -> next cycle sel=0, frame_valid=0, busy=0. A subsequent start produces a complete correct frame.
- DWELL=1 with I=4'b1100 -> frame=4'b1100, frame_valid 4 edges after start. start pulses during SCAN/OUT have no effect.
- With SCAN_PARITY_EN defined, I=4'b0111 -> frame_parity=1; I=4'b0110 -> frame_parity=0.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// Shared types and sizes for the mux scan sequencer: FSM states and channel/frame widths.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int NUM_CH  = 4;
    localparam int SEL_W   = 2;
    localparam int FRAME_W = NUM_CH;

    function automatic logic frame_parity_of(input logic [FRAME_W-1:0] f);
        return ^f;
    endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Frame output channel of the mux scan sequencer.
// With SCAN_PARITY_EN defined the channel also carries frame_parity.
interface mux_scan_sequencer_if;
    import mux_scan_pkg::*;

    // Handshake: a frame transfers on a rising edge where frame_valid and
    // frame_ready are both 1; frame stays stable while frame_valid=1 and
    // frame_ready=0, and frame_valid never drops before acceptance.
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;
    logic               frame_ready;
`ifdef SCAN_PARITY_EN
    logic               frame_parity;

    modport master (output frame, output frame_valid, output frame_parity, input frame_ready);
    modport slave  (input frame, input frame_valid, input frame_parity, output frame_ready);
`else
    modport master (output frame, output frame_valid, input frame_ready);
    modport slave  (input frame, input frame_valid, output frame_ready);
`endif

endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Dwell timer: counts up while enabled and flags the last cycle of a DWELL-long period.
module dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    logic [7:0] count;

    assign terminal = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= 8'd0;
        end else if (enable) begin
            count <= terminal ? 8'd0 : count + 8'd1;
        end
    end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through all channels, samples y after DWELL cycles each,
// and hands the 4-bit frame downstream. Optional macro: SCAN_PARITY_EN adds frame_parity.
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             continuous,
    output logic [SEL_W-1:0] sel,
    input  logic             y,
    output logic             busy,
    output state_t           state_dbg,
    mux_scan_sequencer_if.master fr_if
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

    state_t             state;
    state_t             state_nxt;
    logic               cnt_clear;
    logic               cnt_en;
    logic               terminal;
    logic               frame_valid_c;
    logic               scan_tick;
    logic [FRAME_W-1:0] shadow;
    logic [FRAME_W-1:0] shadow_nxt;
    logic [FRAME_W-1:0] frame_q;

    dwell_counter #(.DWELL(DWELL)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .clear    (cnt_clear),
        .enable   (cnt_en),
        .terminal (terminal)
    );

    assign scan_tick = cnt_en && terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: if (scan_tick && sel == LAST_SEL) state_nxt = OUT;
            OUT:  if (fr_if.frame_ready) state_nxt = continuous ? SCAN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The counter is held clear outside SCAN so every scan starts from count 0.
    always_comb begin
        busy          = 1'b0;
        frame_valid_c = 1'b0;
        cnt_en        = 1'b0;
        cnt_clear     = 1'b1;
        case (state)
            SCAN: begin
                busy      = 1'b1;
                cnt_en    = 1'b1;
                cnt_clear = 1'b0;
            end
            OUT: begin
                busy          = 1'b1;
                frame_valid_c = 1'b1;
            end
            default: ;
        endcase
    end

    // The last channel's sample is folded in on the same edge that publishes the frame.
    always_comb begin
        shadow_nxt      = shadow;
        shadow_nxt[sel] = y;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            shadow  <= '0;
            frame_q <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (scan_tick) begin
                        shadow <= shadow_nxt;
                        if (sel == LAST_SEL) begin
                            frame_q <= shadow_nxt;
                        end else begin
                            sel <= sel + SEL_W'(1);
                        end
                    end
                end
                OUT: if (fr_if.frame_ready) sel <= '0;
                default: sel <= '0;
            endcase
        end
    end

`ifdef SCAN_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (scan_tick && sel == LAST_SEL) begin
            parity_q <= frame_parity_of(shadow_nxt);
        end
    end

    assign fr_if.frame_parity = parity_q;
`endif

    assign fr_if.frame       = frame_q;
    assign fr_if.frame_valid = frame_valid_c;
    assign state_dbg         = state;

endmodule
